// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_pkg
// Brief  : Response codes, FSM states and memory hooks for the AXI4-Lite slave.
// Rev    : 1.0  initial release
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;

  // 16-bit Galois LFSR step, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Behavioural stand-in for the C memory model; unwritten words read as 0.
  int unsigned npc_mem_calls = 0;
  int          npc_mem [int];

  function automatic int npc_mem_read(input int addr);
    npc_mem_calls++;
    return npc_mem.exists(addr) ? npc_mem[addr] : 0;
  endfunction

  function automatic void npc_mem_write(input int addr, input int data, input byte wmask);
    int v;
    npc_mem_calls++;
    v = npc_mem.exists(addr) ? npc_mem[addr] : 0;
    for (int b = 0; b < 4; b++) begin
      if (((wmask & 8'h0F) & (8'h01 << b)) != 8'h00) v[b*8 +: 8] = data[b*8 +: 8];
    end
    npc_mem[addr] = v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_mem_slave_lat_gen.sv
`default_nettype none
// ============================================================================
// Module : lat_gen
// Brief  : LFSR latency source shared by the write and read channels.
// Rev    : 1.0  initial release
// ============================================================================
module lat_gen
  import axi_pkg::*;
#(
  parameter int          DLY_W     = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             rd_req,
  output logic [DLY_W-1:0] wr_dly,
  output logic [DLY_W-1:0] rd_dly
);

  logic [15:0] r_lfsr;
  logic [15:0] w_step1;
  logic [15:0] w_step2;

  assign w_step1 = lfsr_next(r_lfsr);
  assign w_step2 = lfsr_next(w_step1);

  // Write takes the current value; a read sampling in the same cycle takes the next one.
  assign wr_dly = r_lfsr[DLY_W-1:0];
  assign rd_dly = wr_req ? w_step1[DLY_W-1:0] : r_lfsr[DLY_W-1:0];

  always_ff @(posedge clk) begin
    if (rst)                   r_lfsr <= LFSR_SEED;
    else if (wr_req && rd_req) r_lfsr <= w_step2;
    else if (wr_req || rd_req) r_lfsr <= w_step1;
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_mem_slave
// Brief  : AXI4-Lite memory slave with independent read/write FSMs and
//          programmable latency. MEM_RAND_DELAY_EN selects LFSR delays.
// Rev    : 1.0  initial release
// ============================================================================
module axi_lite_mem_slave
  import axi_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE    = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE    = 32'h0800_0000,
  parameter int                DLY_W       = 5,
  parameter int                FIXED_DELAY = 0,
  parameter logic [15:0]       LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp
);

  localparam int              c_BYTES  = DATA_W / 8;
  localparam int              c_WORDS  = DATA_W / 32;
  localparam logic [ADDR_W-1:0] c_ALIGN = ~ADDR_W'(c_BYTES - 1);
  localparam logic [ADDR_W:0] c_WIN_LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_W:0] c_WIN_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - (ADDR_W+1)'(1);

  if (DATA_W != 32 && DATA_W != 64) begin : g_chk_data_w
    $error("axi_lite_mem_slave: DATA_W must be 32 or 64");
  end
  if (LFSR_SEED == 16'h0000) begin : g_chk_seed
    $error("axi_lite_mem_slave: LFSR_SEED must be non-zero");
  end

  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= c_WIN_LO) && ({1'b0, a} <= c_WIN_HI);
  endfunction

  w_state_e            r_wr_state, w_wr_state_nx;
  r_state_e            r_rd_state, w_rd_state_nx;
  logic                r_aw_got, r_w_got;
  logic [ADDR_W-1:0]   r_awaddr, r_araddr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [c_BYTES-1:0]  r_wstrb;
  logic [DLY_W-1:0]    r_wr_dly, r_wr_cnt, r_rd_dly, r_rd_cnt;
  logic [DLY_W-1:0]    w_wr_dly_smp, w_rd_dly_smp;
  resp_e               r_bresp, r_rresp;
  logic                w_aw_hs, w_w_hs, w_ar_hs;
  logic                w_wr_start, w_wr_fire, w_rd_fire;
  logic [ADDR_W-1:0]   w_wr_al, w_rd_al;

  assign awready = (r_wr_state == W_IDLE) && !r_aw_got;
  assign wready  = (r_wr_state == W_IDLE) && !r_w_got;
  assign bvalid  = (r_wr_state == W_RESP);
  assign bresp   = r_bresp;
  assign arready = (r_rd_state == R_IDLE);
  assign rvalid  = (r_rd_state == R_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  assign w_aw_hs    = awvalid && awready;
  assign w_w_hs     = wvalid && wready;
  assign w_ar_hs    = arvalid && arready;
  assign w_wr_start = (r_wr_state == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
  assign w_wr_fire  = (r_wr_state == W_WAIT) && (r_wr_cnt == r_wr_dly);
  assign w_rd_fire  = (r_rd_state == R_WAIT) && (r_rd_cnt == r_rd_dly);
  assign w_wr_al    = r_awaddr & c_ALIGN;
  assign w_rd_al    = r_araddr & c_ALIGN;

`ifdef MEM_RAND_DELAY_EN
  lat_gen #(
    .DLY_W     (DLY_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_lat_gen (
    .clk    (clk),
    .rst    (rst),
    .wr_req (w_wr_start),
    .rd_req (w_ar_hs),
    .wr_dly (w_wr_dly_smp),
    .rd_dly (w_rd_dly_smp)
  );
`else
  assign w_wr_dly_smp = DLY_W'(FIXED_DELAY);
  assign w_rd_dly_smp = DLY_W'(FIXED_DELAY);
`endif

  always_comb begin
    w_wr_state_nx = r_wr_state;
    unique case (r_wr_state)
      W_IDLE:  if (w_wr_start) w_wr_state_nx = W_WAIT;
      W_WAIT:  if (w_wr_fire)  w_wr_state_nx = W_RESP;
      W_RESP:  if (bready)     w_wr_state_nx = W_IDLE;
      default: w_wr_state_nx = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_nx = r_rd_state;
    unique case (r_rd_state)
      R_IDLE:  if (w_ar_hs)   w_rd_state_nx = R_WAIT;
      R_WAIT:  if (w_rd_fire) w_rd_state_nx = R_RESP;
      R_RESP:  if (rready)    w_rd_state_nx = R_IDLE;
      default: w_rd_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nx;
      r_rd_state <= w_rd_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wr_dly <= '0;
      r_wr_cnt <= '0;
      r_araddr <= '0;
      r_rd_dly <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= awaddr;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (bvalid && bready) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
      if (w_wr_start) begin
        r_wr_dly <= w_wr_dly_smp;
        r_wr_cnt <= '0;
      end else if ((r_wr_state == W_WAIT) && !w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + DLY_W'(1);
      end
      if (w_ar_hs) begin
        r_araddr <= araddr;
        r_rd_dly <= w_rd_dly_smp;
        r_rd_cnt <= '0;
      end else if ((r_rd_state == R_WAIT) && !w_rd_fire) begin
        r_rd_cnt <= r_rd_cnt + DLY_W'(1);
      end
    end
  end

  // Memory side effects live in one block so a same-cycle write lands before the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bresp <= OKAY;
      r_rresp <= OKAY;
      r_rdata <= '0;
    end else begin
      if (w_wr_fire) begin
        if (in_win(r_awaddr)) begin
          for (int k = 0; k < c_WORDS; k++) begin
            if ((c_WORDS == 1) || (r_wstrb[k*4 +: 4] != 4'h0)) begin
              npc_mem_write(int'(w_wr_al) + 4*k, int'(r_wdata[k*32 +: 32]),
                            byte'({4'h0, r_wstrb[k*4 +: 4]}));
            end
          end
          r_bresp <= OKAY;
        end else begin
          r_bresp <= DECERR;
        end
      end
      if (w_rd_fire) begin
        if (in_win(r_araddr)) begin
          for (int k = 0; k < c_WORDS; k++) begin
            r_rdata[k*32 +: 32] <= npc_mem_read(int'(w_rd_al) + 4*k);
          end
          r_rresp <= OKAY;
        end else begin
          r_rdata <= '0;
          r_rresp <= DECERR;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- Parametrised AXI4-Lite memory slave for the NPC multicycle core; successor to the single-width, fixed-random-delay memory model.
- Independent read and write channel FSMs, each with per-transaction programmable latency.
- VALID is held until the READY handshake completes.
- Memory accesses go through the DPI-C functions npc_mem_read / npc_mem_write. Accesses outside a configured window return DECERR.

Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64.
- ADDR_W, 32, address width.
- MEM_BASE, 32'h8000_0000, first valid byte address.
- MEM_SIZE, 32'h0800_0000, window size in bytes.
- DLY_W, 5, delay counter width; max delay is 2^DLY_W-1 cycles.
- FIXED_DELAY, 0, latency used when MEM_RAND_DELAY_EN is undefined.
- LFSR_SEED, 16'hACE1, LFSR reset value.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  ADDR_W  write address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response code
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  ADDR_W  read address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  DATA_W  read data, full aligned beat
- rresp  out  2  read response code

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, both FSMs IDLE, counters 0, LFSR=LFSR_SEED.
- Reset mid-transaction: the pending transaction is dropped with no DPI call.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - In W_IDLE, AW and W are accepted independently in any order or the same cycle.
  - On an AW handshake, awaddr is latched and awready drops. On a W handshake, wdata/wstrb are latched and wready drops.
  - When both are latched, the FSM samples the delay d and enters W_WAIT.
- W_WAIT: the counter runs 0..d. On the cycle count==d:
  - In-window address: call npc_mem_write with the aligned address, data and strobes; bresp=OKAY (00).
  - Out-of-window address: no DPI call; bresp=DECERR (11).
  - Enter W_RESP with bvalid=1.
- W_RESP: bvalid and bresp are held until bready. On the handshake, bvalid=0, awready=wready=1, return to W_IDLE.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On an AR handshake, araddr is latched, arready drops, the delay is sampled, enter R_WAIT.
  - At count==d: in-window address calls npc_mem_read, and rdata is registered with rresp=OKAY. Out-of-window address gives rdata=0, rresp=DECERR.
  - R_RESP: rvalid, rdata and rresp are held stable until rready, then arready=1 and return to R_IDLE.
- Latency: with the handshake at edge N and delay d, VALID rises at edge N+1+d. d=0 gives a 1-cycle response.
- Alignment:
  - The address passed to DPI is addr with the low log2(DATA_W/8) bits cleared.
  - For DATA_W=64, two 32-bit DPI calls are made: addr, then addr+4. The strobe halves go to the respective calls, and a call is skipped if its half strobe is 0.
  - Byte/half extraction and sign extension are not done here; they are the requester's job.
- Window check: MEM_BASE <= addr <= MEM_BASE+MEM_SIZE-1, computed at ADDR_W+1 bits so there is no wrap at the top of the address space.
- Simultaneous write and read completion in the same cycle: the write DPI executes before the read DPI, so the read returns the new data.
- Channels are fully independent; neither FSM ever stalls the other.

Optional Feature:
- MEM_RAND_DELAY_EN defined: d = LFSR[DLY_W-1:0]. The LFSR is a 16-bit Galois LFSR with taps 16,14,13,11. It advances once per sample, and a write and a read sampling in the same cycle take consecutive values, write first.
- MEM_RAND_DELAY_EN undefined: d = FIXED_DELAY for every transaction, and no LFSR is instantiated.

Decomposition:
- Shared package axi_pkg holds:
  - resp_e typedef: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - w_state_e and r_state_e FSM enums.
  - The DPI import declarations.
- Sub-module: lat_gen holds the LFSR plus the sample-request arbitration and outputs two d values. It is instantiated only under MEM_RAND_DELAY_EN.

Test Plan:
- FIXED_DELAY=3: AW and W in the same cycle at 0x8000_0010, wdata 0xDEADBEEF, wstrb 0xF -> bvalid rises 4 cycles later, bresp=00, memory word updated.
- W arrives 5 cycles before AW -> wready low after the W handshake, awready stays high until AW; the write occurs only after both are captured.
- Read 0x8000_0010 with rready held low for 6 cycles -> rvalid and rdata=0xDEADBEEF stay stable throughout; arready=0 until the rready handshake.
- Read 0x0000_0100 and write 0xFFFF_FFFC (out of window) -> rresp=11, rdata=0, bresp=11, no DPI calls.
- Write and read of the same address completing in the same cycle -> the read returns the newly written value; for DATA_W=64 with wstrb 0x0F, only the lower word is written.
- Assert rst while in W_WAIT -> bvalid stays 0, no write occurs, awready=wready=1 on the next cycle.
